// File: rtl/packet_transfer_mux.sv
// packet_transfer_mux: round-robin serializer that streams whole packets from NUM_SRC sources as flits.
// Optional stall timeout with abort and a one-cycle DRAIN state: define PACKET_TRANSFER_MUX_TIMEOUT_EN.

package types;
  localparam int FLIT_W    = 16;
  localparam int MAX_FLITS = 16;
  typedef logic [FLIT_W-1:0] flit_t;
  // tail_index counts flits in the packet; legal values are 0..MAX_FLITS-1.
  typedef logic [$clog2(MAX_FLITS)-1:0] flit_num_t;
endpackage

package packet_types;
  typedef struct packed {
    types::flit_t [types::MAX_FLITS-1:0] buffer;
    types::flit_num_t                    tail_index;
  } packet_element_t;
endpackage

module packet_transfer_mux #(
  parameter int NUM_SRC        = 2,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                           nocclk,
  input  logic                           rst_n,
  input  packet_types::packet_element_t  src_packet [NUM_SRC],
  input  logic [NUM_SRC-1:0]             src_packet_valid,
  output logic [NUM_SRC-1:0]             src_packet_completed,
  output logic [NUM_SRC-1:0]             src_packet_aborted,
  input  logic                           transfered_flit_ready,
  output logic                           transfered_flit_valid,
  output types::flit_t                   transfered_flit,
  output types::flit_t                   transfered_head_flit,
  output logic [$clog2(NUM_SRC)-1:0]     transfered_src_id
);

  localparam int ID_W = $clog2(NUM_SRC);

  if (NUM_SRC < 2 || NUM_SRC > 8 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_param_check
    $error("packet_transfer_mux: parameter out of range");
  end

`ifdef PACKET_TRANSFER_MUX_TIMEOUT_EN
  typedef enum logic [1:0] {IDLE, SEND, DRAIN} state_t;
  localparam int STALL_W = 16;
  logic [STALL_W-1:0] stall_cnt, stall_nxt;
  logic [NUM_SRC-1:0] abort_vec;
`else
  typedef enum logic [0:0] {IDLE, SEND} state_t;
`endif

  // Exposed FSM state for checkers and debug.
  state_t           state, state_nxt;
  types::flit_num_t cnt, cnt_nxt;
  logic [ID_W-1:0]  rr_ptr, rr_nxt;
  logic [ID_W-1:0]  grant_id, grant_nxt;

  logic             found;
  logic [ID_W-1:0]  pick;
  logic [ID_W-1:0]  cand;
  logic [ID_W-1:0]  next_id;
  logic             cur_valid;
  logic             flit_ok;
  logic             last_flit;
  types::flit_num_t cnt_inc;
  packet_types::packet_element_t cur;

  // Round-robin search starting at rr_ptr, wrapping from NUM_SRC-1 to 0.
  always_comb begin
    found = 1'b0;
    pick  = rr_ptr;
    cand  = rr_ptr;
    for (int i = 0; i < NUM_SRC; i++) begin
      cand = ID_W'((int'(rr_ptr) + i) % NUM_SRC);
      if (!found && src_packet_valid[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  assign cur       = src_packet[grant_id];
  assign cur_valid = src_packet_valid[grant_id];
  assign cnt_inc   = cnt + 1'b1;
  assign last_flit = (cnt_inc == cur.tail_index);
  assign next_id   = (grant_id == ID_W'(NUM_SRC - 1)) ? '0 : grant_id + 1'b1;

  // Handshake: a flit moves in every cycle where valid and ready are both high;
  // valid is a function of source state and cnt only, never of ready.
  always_comb begin
    state_nxt             = state;
    cnt_nxt               = cnt;
    rr_nxt                = rr_ptr;
    grant_nxt             = grant_id;
    flit_ok               = 1'b0;
    transfered_flit_valid = 1'b0;
    transfered_flit       = '0;
    transfered_head_flit  = '0;
    transfered_src_id     = '0;
    src_packet_completed  = '0;
`ifdef PACKET_TRANSFER_MUX_TIMEOUT_EN
    stall_nxt             = stall_cnt;
    abort_vec             = '0;
`endif
    case (state)
      IDLE: begin
        if (found) begin
          state_nxt = SEND;
          cnt_nxt   = '0;
          grant_nxt = pick;
        end
      end
      SEND: begin
        flit_ok               = cur_valid && (cnt < cur.tail_index);
        transfered_flit_valid = flit_ok;
        transfered_flit       = cur.buffer[cnt];
        transfered_head_flit  = cur.buffer[0];
        transfered_src_id     = grant_id;
        if (cur_valid && (cur.tail_index == '0)) begin
          // Empty packet: retire it without emitting any flit.
          src_packet_completed[grant_id] = 1'b1;
          state_nxt = IDLE;
          cnt_nxt   = '0;
          rr_nxt    = next_id;
`ifdef PACKET_TRANSFER_MUX_TIMEOUT_EN
          stall_nxt = '0;
`endif
        end else if (flit_ok && transfered_flit_ready) begin
`ifdef PACKET_TRANSFER_MUX_TIMEOUT_EN
          stall_nxt = '0;
`endif
          if (last_flit) begin
            src_packet_completed[grant_id] = 1'b1;
            state_nxt = IDLE;
            cnt_nxt   = '0;
            rr_nxt    = next_id;
          end else begin
            cnt_nxt = cnt_inc;
          end
        end
`ifdef PACKET_TRANSFER_MUX_TIMEOUT_EN
        else if (flit_ok) begin
          // This is a stalled cycle; the one that reaches the limit aborts the packet.
          if (stall_cnt == STALL_W'(TIMEOUT_CYCLES - 1)) begin
            abort_vec[grant_id] = 1'b1;
            state_nxt = DRAIN;
            cnt_nxt   = '0;
            rr_nxt    = next_id;
            stall_nxt = '0;
          end else begin
            stall_nxt = stall_cnt + 1'b1;
          end
        end
`endif
      end
`ifdef PACKET_TRANSFER_MUX_TIMEOUT_EN
      DRAIN: begin
        state_nxt = IDLE;
      end
`endif
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

`ifdef PACKET_TRANSFER_MUX_TIMEOUT_EN
  assign src_packet_aborted = abort_vec;
`else
  assign src_packet_aborted = '0;
`endif

  always_ff @(posedge nocclk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      rr_ptr   <= '0;
      grant_id <= '0;
`ifdef PACKET_TRANSFER_MUX_TIMEOUT_EN
      stall_cnt <= '0;
`endif
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      rr_ptr   <= rr_nxt;
      grant_id <= grant_nxt;
`ifdef PACKET_TRANSFER_MUX_TIMEOUT_EN
      stall_cnt <= stall_nxt;
`endif
    end
  end

endmodule
